// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle between the CPU and the multiply/divide sequencer.
// The CPU side is the master, the sequencer the slave.
interface alu_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start,
    output op,
    output opa,
    output opb,
    input  busy,
    input  done,
    input  div_zero,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  op,
    input  opa,
    input  opb,
    output busy,
    output done,
    output div_zero,
    output hi,
    output lo
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Multi-cycle unsigned multiply / restoring divide sequencer.
// Borrows the shared ALU: one add or subtract per iteration.
module alu_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_mdu_seq_if.slave    bus,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctr,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_co
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            op_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            dz_q;

  logic [XLEN-1:0] div_t;
  logic            div_msb;
  logic            div_take;
  logic            run_mul;
  logic            run_div;

  assign run_mul = (state_q == S_RUN) && !op_q;
  assign run_div = (state_q == S_RUN) && op_q;

  // msb covers the 33-bit partial remainder that t cannot hold
  always_comb begin
    div_t    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    div_msb  = hi_q[XLEN-1];
    div_take = div_msb | alu_co;
  end

  always_comb begin
    alu_ctr = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    unique case (1'b1)
      run_mul: begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? m_q : '0;
      end
      run_div: begin
        alu_ctr = ALU_SUB;
        alu_a   = div_t;
        alu_b   = m_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            m_q   <= bus.opb;
            cnt_q <= '0;
            dz_q  <= 1'b0;
            if (bus.op && (bus.opb == '0)) begin
              lo_q    <= '1;
              hi_q    <= bus.opa;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              lo_q    <= bus.opa;
              hi_q    <= '0;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_q) begin
            if (div_take) begin
              hi_q <= alu_res;
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_q <= div_t;
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_q <= {alu_co, alu_res[XLEN-1:1]};
            lo_q <= {alu_res[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == '1) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq with a behavioural ALU beside it.
// Expected results are hand-computed constants.
module tb_alu_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        alu_co;

  int errs;
  int checks;
  int dones;

  alu_mdu_seq_if #(.XLEN(32)) bus ();

  alu_mdu_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_res (alu_res),
    .alu_co  (alu_co)
  );

  always_comb begin
    if (alu_ctr == 3'b110)
      {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    else
      {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Waits for done, checking latency, first-cycle flags and results
  task automatic wait_done(input string tag, input logic op,
                           input int exp_n, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz,
                           input bit poke);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opa   = 32'd3;
        bus.opb   = 32'd3;
      end
      if (poke && n == 6) bus.start = 1'b0;
      if (n == 1) begin
        chk({tag, ".busy1"}, 64'(bus.busy), 64'(exp_n != 1));
        chk({tag, ".ctr1"}, 64'(alu_ctr),
            64'((op && exp_n != 1) ? 3'b110 : 3'b010));
      end
      if (bus.done) break;
      if (n >= 40) break;
    end
    chk({tag, ".lat"}, 64'(n), 64'(exp_n));
    chk({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
    chk({tag, ".dz"}, 64'(bus.div_zero), 64'(exp_dz));
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    dones     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.hi", 64'(bus.hi), 64'd0);
    chk("rst.lo", 64'(bus.lo), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.dz", 64'(bus.div_zero), 64'd0);
    chk("rst.ctr", 64'(alu_ctr), 64'd2);

    issue(1'b0, 32'd7, 32'd6);
    wait_done("mul7x6", 1'b0, 33, 32'd0, 32'd42, 1'b0, 1'b0);
    @(negedge clk);
    chk("mul7x6.done_drop", 64'(bus.done), 64'd0);
    chk("mul7x6.hold_lo", 64'(bus.lo), 64'd42);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulmax", 1'b0, 33, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul2p16", 1'b0, 33, 32'h1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    issue(1'b1, 32'd100, 32'd7);
    wait_done("div100_7", 1'b1, 33, 32'd2, 32'd14, 1'b0, 1'b0);
    @(negedge clk);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1);
    wait_done("divmax_1", 1'b1, 33, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divmsb", 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    @(negedge clk);

    issue(1'b1, 32'd5, 32'd0);
    wait_done("div0", 1'b1, 1, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    chk("div0.hold_dz", 64'(bus.div_zero), 64'd1);
    issue(1'b1, 32'd1000, 32'd10);
    @(negedge clk);
    chk("dz_clear", 64'(bus.div_zero), 64'd0);
    wait_done("div1000_10", 1'b1, 32, 32'd0, 32'd100, 1'b0, 1'b0);
    @(negedge clk);

    issue(1'b0, 32'd7, 32'd6);
    wait_done("ignore", 1'b0, 33, 32'd0, 32'd42, 1'b0, 1'b1);

    // accept straight out of DONE
    issue(1'b1, 32'h1234_5678, 32'h0000_1000);
    wait_done("b2b", 1'b1, 33, 32'h678, 32'h12345, 1'b0, 1'b0);
    chk("b2b.prev_done_gap", 64'(dones), 64'd0);
    @(negedge clk);

    issue(1'b0, 32'd7, 32'd6);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(bus.busy), 64'd0);
    chk("abort.hi", 64'(bus.hi), 64'd0);
    chk("abort.lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort.no_done", 64'(dones), 64'd0);
    chk("abort.busy_late", 64'(bus.busy), 64'd0);
    chk("abort.lo_late", 64'(bus.lo), 64'd0);
    chk("abort.ctr", 64'(alu_ctr), 64'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
